// File: rtl/slc3_pkg.sv
// Shared state encoding and MMIO address for the SLC-3 memory/IO sequencer.
package slc3_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_SETUP = 2'd1,
    WR_PULSE = 2'd2,
    WR_HOLD  = 2'd3
  } mem_state_t;

  localparam logic [19:0] SLC3_IO_ADDR = 20'hFFFF;

endpackage

// File: rtl/slc3_mem_io_sync2.sv
// Parameterised two-flop synchronizer for asynchronous board inputs.
// Latency: 2 Clk cycles; no flow control, samples every cycle.
module sync2 #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/slc3_mem_io.sv
// SLC-3 memory/IO sequencer: async SRAM strobes, one MMIO word, PAUSE LED register.
// Latency: strobes/address lag inputs by 1 cycle; writes take 3 cycles and ignore new WE until IDLE.
module slc3_mem_io
  import slc3_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 20,
  parameter int unsigned       DATA_W  = 16,
  parameter logic [ADDR_W-1:0] IO_ADDR = SLC3_IO_ADDR,
  parameter int unsigned       LED_W   = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_from_CPU,
  output logic [DATA_W-1:0] Data_to_CPU,
  input  logic [DATA_W-1:0] Switches,
  input  logic              LD_LED,
  input  logic [LED_W-1:0]  IR_LED,
  output logic [LED_W-1:0]  LED,
  output logic [DATA_W-1:0] HEX_Data,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  inout  wire logic [DATA_W-1:0] SRAM_DQ
);

  mem_state_t        r_state;
  mem_state_t        w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_hex;
  logic [LED_W-1:0]  r_led;
  logic              r_ce_n;
  logic              r_ub_n;
  logic              r_lb_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_we_prev;

  logic              w_io_hit;
  logic              w_we_fall;
  logic              w_start;
  logic              w_mmio_wr;
  logic              w_dq_drive;
  logic [DATA_W-1:0] w_sw_sync;

  sync2 #(.W(DATA_W)) u_sw_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .i_d   (Switches),
    .o_q   (w_sw_sync)
  );

  assign w_io_hit  = (ADDR == IO_ADDR);
  assign w_we_fall = ~Mem_WE & r_we_prev & ~Mem_CE;
  assign w_start   = w_we_fall & ~w_io_hit & (r_state == IDLE);
  assign w_mmio_wr = w_we_fall &  w_io_hit & (r_state == IDLE);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_start) w_next_state = WR_SETUP;
      WR_SETUP: w_next_state = WR_PULSE;
      WR_PULSE: w_next_state = WR_HOLD;
      WR_HOLD:  w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_hex     <= '0;
      r_led     <= '0;
      r_ce_n    <= 1'b1;
      r_ub_n    <= 1'b1;
      r_lb_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_we_prev <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_we_prev <= Mem_WE;
      r_ce_n    <= Mem_CE;
      r_ub_n    <= Mem_UB;
      r_lb_n    <= Mem_LB;
      // Read strobe is held off until the write FSM has released DQ.
      r_oe_n    <= Mem_OE | Mem_CE | w_io_hit | (w_next_state != IDLE);
      r_we_n    <= (w_next_state != WR_PULSE);
      // Address is captured on the start edge and frozen across SETUP/PULSE/HOLD.
      if (w_start || (w_next_state == IDLE)) r_addr <= ADDR;
      if (w_start) r_wdata <= Data_from_CPU;
      if (w_mmio_wr) r_hex <= Data_from_CPU;
      if (LD_LED) r_led <= IR_LED;
    end
  end

  assign w_dq_drive  = (r_state != IDLE);
  assign SRAM_DQ     = w_dq_drive ? r_wdata : {DATA_W{1'bz}};
  assign Data_to_CPU = (r_addr == IO_ADDR) ? w_sw_sync : SRAM_DQ;

  assign SRAM_ADDR = r_addr;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_UB_N = r_ub_n;
  assign SRAM_LB_N = r_lb_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_WE_N = r_we_n;
  assign HEX_Data  = r_hex;
  assign LED       = r_led;

endmodule

// File: tb/tb_slc3_mem_io.sv
// Directed bench for slc3_mem_io with a small async SRAM model and a DQ probe driver.
module tb_slc3_mem_io;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [19:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic [15:0] Switches;
  logic        LD_LED;
  logic [11:0] IR_LED;
  logic [11:0] LED;
  logic [15:0] HEX_Data;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;
  wire  [15:0] SRAM_DQ;

  logic [15:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;
  logic        probe_en;
  logic [15:0] probe_val;
  logic        sram_rd;
  logic        tb_en;
  logic [15:0] tb_val;
  int          we_low_cnt = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          snap;

  always #5 Clk = ~Clk;

  slc3_mem_io dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Mem_CE        (Mem_CE),
    .Mem_UB        (Mem_UB),
    .Mem_LB        (Mem_LB),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Data_to_CPU   (Data_to_CPU),
    .Switches      (Switches),
    .LD_LED        (LD_LED),
    .IR_LED        (IR_LED),
    .LED           (LED),
    .HEX_Data      (HEX_Data),
    .SRAM_ADDR     (SRAM_ADDR),
    .SRAM_CE_N     (SRAM_CE_N),
    .SRAM_UB_N     (SRAM_UB_N),
    .SRAM_LB_N     (SRAM_LB_N),
    .SRAM_OE_N     (SRAM_OE_N),
    .SRAM_WE_N     (SRAM_WE_N),
    .SRAM_DQ       (SRAM_DQ)
  );

  // SRAM model: reads drive DQ while OE_N/CE_N low; writes land on the edge ending a WE_N-low cycle.
  assign sram_rd = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign tb_en   = sram_rd || probe_en;
  assign tb_val  = sram_rd ? mem[SRAM_ADDR[7:0]] : probe_val;
  assign SRAM_DQ = tb_en ? tb_val : 16'hzzzz;

  always @(posedge Clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ[15:8];
    end
  end

  always @(negedge Clk) if (SRAM_WE_N === 1'b0) we_low_cnt <= we_low_cnt + 1;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A released DQ lets the probe value through to Data_to_CPU; a driven one corrupts it.
  task automatic chk_dq_z(input string tag, input logic [15:0] pv);
    probe_val = pv;
    probe_en  = 1'b1;
    #1;
    chk(tag, {16'h0, Data_to_CPU}, {16'h0, pv});
    probe_en  = 1'b0;
  endtask

  task automatic idle_bus();
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; Mem_CE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b1;
    ADDR = '0; Data_from_CPU = '0; Switches = '0; LD_LED = 1'b0; IR_LED = '0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0; probe_en = 1'b0; probe_val = '0;

    tick(); tick();
    chk("rst_ce_n", {31'h0, SRAM_CE_N}, 32'h1);
    chk("rst_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    chk("rst_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    chk("rst_ub_lb_n", {30'h0, SRAM_UB_N, SRAM_LB_N}, 32'h3);
    chk("rst_addr", {12'h0, SRAM_ADDR}, 32'h0);
    chk("rst_led", {20'h0, LED}, 32'h0);
    chk("rst_hex", {16'h0, HEX_Data}, 32'h0);
    chk_dq_z("rst_dq_z", 16'h5AA5);

    Reset = 1'b0;
    pl_en = 1'b1; pl_a = 8'h10; pl_d = 16'h1234;
    tick();
    pl_en = 1'b0;

    // Read: OE low for two cycles at 0x0010.
    Mem_CE = 1'b0; Mem_OE = 1'b0; ADDR = 20'h00010;
    #1 chk("rd_c1_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    tick();
    chk("rd_c2_oe_n", {31'h0, SRAM_OE_N}, 32'h0);
    chk("rd_c2_addr", {12'h0, SRAM_ADDR}, 32'h10);
    chk("rd_c2_data", {16'h0, Data_to_CPU}, 32'h1234);
    idle_bus();
    tick();
    chk("rd_c3_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    chk("rd_c3_ce_n", {31'h0, SRAM_CE_N}, 32'h1);

    // Write: WE low two cycles, 0xBEEF to 0x0020; address moves after WE rises.
    snap = we_low_cnt;
    Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 20'h00020; Data_from_CPU = 16'hBEEF;
    tick();
    chk("wr_setup_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    chk("wr_setup_addr", {12'h0, SRAM_ADDR}, 32'h20);
    chk("wr_setup_dq", {16'h0, Data_to_CPU}, 32'hBEEF);
    Data_from_CPU = 16'h0000;
    tick();
    chk("wr_pulse_we_n", {31'h0, SRAM_WE_N}, 32'h0);
    Mem_WE = 1'b1; ADDR = 20'h00030;
    tick();
    chk("wr_hold_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    chk("wr_hold_addr", {12'h0, SRAM_ADDR}, 32'h20);
    chk("wr_hold_dq", {16'h0, Data_to_CPU}, 32'hBEEF);
    tick();
    chk("wr_c4_addr", {12'h0, SRAM_ADDR}, 32'h30);
    chk_dq_z("wr_c4_dq_z", 16'h0F0F);
    chk("wr_mem", {16'h0, mem[8'h20]}, 32'hBEEF);
    chk("wr_one_pulse", we_low_cnt - snap, 32'd1);
    idle_bus();
    tick();

    // Write then fetch: OE requested during PULSE and HOLD is deferred until DQ release.
    snap = we_low_cnt;
    Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 20'h00040; Data_from_CPU = 16'hCAFE;
    tick();
    tick();
    Mem_WE = 1'b1; Mem_OE = 1'b0; ADDR = 20'h00010;
    tick();
    chk("wf_hold_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    chk("wf_hold_dq", {16'h0, Data_to_CPU}, 32'hCAFE);
    tick();
    chk("wf_rel_oe_n", {31'h0, SRAM_OE_N}, 32'h0);
    chk("wf_rel_addr", {12'h0, SRAM_ADDR}, 32'h10);
    chk("wf_rel_data", {16'h0, Data_to_CPU}, 32'h1234);
    chk("wf_mem", {16'h0, mem[8'h40]}, 32'hCAFE);
    chk("wf_one_pulse", we_low_cnt - snap, 32'd1);
    idle_bus();
    tick();

    // WE held low for six cycles must not retrigger.
    snap = we_low_cnt;
    Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 20'h00050; Data_from_CPU = 16'h1111;
    for (int i = 0; i < 6; i++) tick();
    chk("hold_we_one_pulse", we_low_cnt - snap, 32'd1);
    chk("hold_we_mem", {16'h0, mem[8'h50]}, 32'h1111);
    idle_bus();
    tick();

    // OE and WE low together: write wins.
    Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0; ADDR = 20'h00060; Data_from_CPU = 16'h2222;
    tick();
    chk("oewe_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    chk("oewe_dq", {16'h0, Data_to_CPU}, 32'h2222);
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    tick(); tick(); tick();
    chk("oewe_mem", {16'h0, mem[8'h60]}, 32'h2222);
    idle_bus();
    tick();

    // MMIO write to the hex register.
    snap = we_low_cnt;
    Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 20'hFFFF; Data_from_CPU = 16'h00AB;
    tick();
    chk("mmio_hex", {16'h0, HEX_Data}, 32'h00AB);
    Mem_WE = 1'b1;
    tick(); tick(); tick();
    chk("mmio_no_we", we_low_cnt - snap, 32'd0);
    idle_bus();
    tick();

    // Falling WE with CE high is ignored.
    Mem_CE = 1'b1; Mem_WE = 1'b0; ADDR = 20'hFFFF; Data_from_CPU = 16'h00CD;
    tick();
    chk("ce_off_hex", {16'h0, HEX_Data}, 32'h00AB);
    chk("ce_off_ce_n", {31'h0, SRAM_CE_N}, 32'h1);
    idle_bus();
    tick();

    // Switch read through the synchronizer.
    Switches = 16'h5A5A; Mem_CE = 1'b0; Mem_OE = 1'b0; ADDR = 20'hFFFF;
    tick();
    chk("sw_c1_data", {16'h0, Data_to_CPU}, 32'h0000);
    chk("sw_c1_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    tick();
    chk("sw_c2_data", {16'h0, Data_to_CPU}, 32'h5A5A);
    idle_bus();
    tick();

    // LED load and hold.
    LD_LED = 1'b1; IR_LED = 12'hF0F;
    tick();
    chk("led_load", {20'h0, LED}, 32'hF0F);
    LD_LED = 1'b0; IR_LED = 12'h123;
    tick();
    chk("led_hold", {20'h0, LED}, 32'hF0F);

    // Reset during WR_PULSE.
    Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 20'h00070; Data_from_CPU = 16'h3333;
    tick();
    tick();
    chk("rstw_pulse_we_n", {31'h0, SRAM_WE_N}, 32'h0);
    Reset = 1'b1;
    tick();
    chk("rstw_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    chk("rstw_led", {20'h0, LED}, 32'h0);
    chk("rstw_hex", {16'h0, HEX_Data}, 32'h0);
    chk_dq_z("rstw_dq_z", 16'hA5C3);
    Reset = 1'b0;
    idle_bus();
    tick(); tick();
    chk_dq_z("rstw_idle_dq_z", 16'h3C3C);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
